// File: rtl/spart_driver_if.sv
// SPART I/O bus control signals shared between the processor-side driver
// (master) and the bus_interface block (slave). The 8-bit databus is a
// tristate net and travels as a plain inout port next to this interface.
interface spart_driver_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;

   modport master (
      output iocs,
      output iorw,
      output ioaddr
   );

   modport slave (
      input iocs,
      input iorw,
      input ioaddr
   );
endinterface

// File: rtl/spart_driver.sv
// Processor-side master of the SPART I/O bus. After reset it programs the
// baud divisor (low byte, then high byte), then polls STATUS forever, moving
// received bytes to a host valid/ready port and host bytes into the SPART
// transmit register. Every access is one cycle long and is followed by one
// idle turnaround cycle, so the two sides never drive databus together.
//
// state_q names the bus cycle that is issued on the next clock edge; the bus
// output flops therefore show the cycle chosen one clock earlier. Decisions
// that need the SPART's answer (STATUS after POLL, byte after RD_DATA) are
// taken at the edge that closes that access, by decoding the output flops.
module spart_driver #(
   parameter int POLL_GAP = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           div,
   spart_driver_if.master        bus,
   inout  wire  [7:0]            databus,
   input  logic [7:0]            tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [7:0]            rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  cfg_done
);

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      POLL,
      RD_DATA,
      WR_DATA,
      TURN,
      GAP
   } state_t;

   localparam logic [1:0] ADDR_DATA    = 2'b00;
   localparam logic [1:0] ADDR_STATUS  = 2'b01;
   localparam logic [1:0] ADDR_DB_LOW  = 2'b10;
   localparam logic [1:0] ADDR_DB_HIGH = 2'b11;

   // Number of extra GAP cycles after the first one; the counter only counts down to zero.
   localparam logic [3:0] GAP_INIT = (POLL_GAP > 0) ? 4'(POLL_GAP - 1) : 4'd0;

   state_t     state_q, state_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;

   logic       iocs_q, iocs_d;
   logic       iorw_q, iorw_d;
   logic [1:0] ioaddr_q, ioaddr_d;
   logic       drv_en_q, drv_en_d;
   logic [7:0] drv_data_q, drv_data_d;

   logic       tx_full_q, tx_full_d;
   logic [7:0] tx_hold_q, tx_hold_d;
   logic       tx_ready_q, tx_ready_d;

   logic       rx_valid_q, rx_valid_d;
   logic [7:0] rx_data_q, rx_data_d;

   logic       cfg_done_q, cfg_done_d;

   logic       bus_poll;
   logic       bus_rd;
   logic       bus_wr;
   logic       bus_cfg_lo;
   logic       bus_cfg_hi;
   logic       poll_rda;
   logic       poll_tbr;

   // Identify which access is currently on the bus from the registered outputs.
   always_comb begin
      bus_poll   = iocs_q &&  iorw_q && (ioaddr_q == ADDR_STATUS);
      bus_rd     = iocs_q &&  iorw_q && (ioaddr_q == ADDR_DATA);
      bus_wr     = iocs_q && !iorw_q && (ioaddr_q == ADDR_DATA);
      bus_cfg_lo = iocs_q && !iorw_q && (ioaddr_q == ADDR_DB_LOW);
      bus_cfg_hi = iocs_q && !iorw_q && (ioaddr_q == ADDR_DB_HIGH);
      poll_rda   = databus[0];
      poll_tbr   = databus[1];
   end

   // Sequencer: every access is followed by TURN; the post-POLL decision gives reads priority over writes.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         CFG_LO, CFG_HI, POLL, RD_DATA, WR_DATA: begin
            state_d = TURN;
         end
         TURN: begin
            if (bus_poll) begin
               if (poll_rda && !rx_valid_q) begin
                  state_d = RD_DATA;
               end else if (poll_tbr && tx_full_q && cfg_done_q) begin
                  state_d = WR_DATA;
               end else if (POLL_GAP == 0) begin
                  state_d = POLL;
               end else begin
                  state_d   = GAP;
                  gap_cnt_d = GAP_INIT;
               end
            end else if (bus_cfg_lo) begin
               state_d = CFG_HI;
            end else begin
               state_d = POLL;
            end
         end
         GAP: begin
            if (gap_cnt_q == 4'd0) begin
               state_d = POLL;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = CFG_LO;
         end
      endcase
   end

   // Bus outputs for the cycle named by state_q, registered at the next edge.
   always_comb begin
      iocs_d     = 1'b0;
      iorw_d     = 1'b1;
      ioaddr_d   = ADDR_DATA;
      drv_en_d   = 1'b0;
      drv_data_d = 8'h00;
      case (state_q)
         CFG_LO: begin
            iocs_d     = 1'b1;
            iorw_d     = 1'b0;
            ioaddr_d   = ADDR_DB_LOW;
            drv_en_d   = 1'b1;
            drv_data_d = div[7:0];
         end
         CFG_HI: begin
            iocs_d     = 1'b1;
            iorw_d     = 1'b0;
            ioaddr_d   = ADDR_DB_HIGH;
            drv_en_d   = 1'b1;
            drv_data_d = div[15:8];
         end
         POLL: begin
            iocs_d   = 1'b1;
            ioaddr_d = ADDR_STATUS;
         end
         RD_DATA: begin
            iocs_d   = 1'b1;
            ioaddr_d = ADDR_DATA;
         end
         WR_DATA: begin
            iocs_d     = 1'b1;
            iorw_d     = 1'b0;
            ioaddr_d   = ADDR_DATA;
            drv_en_d   = 1'b1;
            drv_data_d = tx_hold_q;
         end
         default: begin
            iocs_d = 1'b0;
         end
      endcase
   end

   // Host-side holding registers: tx empties when its write closes, rx fills when its read closes.
   always_comb begin
      tx_full_d  = tx_full_q;
      tx_hold_d  = tx_hold_q;
      rx_valid_d = rx_valid_q;
      rx_data_d  = rx_data_q;
      cfg_done_d = cfg_done_q || bus_cfg_hi;
      if (bus_wr) begin
         tx_full_d = 1'b0;
      end
      if (tx_valid && tx_ready_q) begin
         tx_full_d = 1'b1;
         tx_hold_d = tx_data;
      end
      tx_ready_d = !tx_full_d;
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      if (bus_rd) begin
         rx_valid_d = 1'b1;
         rx_data_d  = databus;
      end
   end

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CFG_LO;
         gap_cnt_q  <= 4'd0;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         ioaddr_q   <= ADDR_DATA;
         drv_en_q   <= 1'b0;
         drv_data_q <= 8'h00;
         tx_full_q  <= 1'b0;
         tx_hold_q  <= 8'h00;
         tx_ready_q <= 1'b1;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
         cfg_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         iocs_q     <= iocs_d;
         iorw_q     <= iorw_d;
         ioaddr_q   <= ioaddr_d;
         drv_en_q   <= drv_en_d;
         drv_data_q <= drv_data_d;
         tx_full_q  <= tx_full_d;
         tx_hold_q  <= tx_hold_d;
         tx_ready_q <= tx_ready_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         cfg_done_q <= cfg_done_d;
      end
   end

   assign databus    = drv_en_q ? drv_data_q : 8'hzz;
   assign bus.iocs   = iocs_q;
   assign bus.iorw   = iorw_q;
   assign bus.ioaddr = ioaddr_q;
   assign tx_ready   = tx_ready_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign cfg_done   = cfg_done_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver. Instance a (POLL_GAP=2) talks to a small
// bus_interface model that answers STATUS with {6'h0,tbr,rda} and DATA reads
// with a scripted byte. Instance b (POLL_GAP=0) only polls an idle SPART.
module tb_spart_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] div;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        cfg_done;

   logic        b_tx_ready;
   logic [7:0]  b_rx_data;
   logic        b_rx_valid;
   logic        b_cfg_done;

   logic        rda;
   logic        tbr;
   logic [7:0]  rd_byte;
   logic        slave_en_a;
   logic [7:0]  slave_val_a;
   logic        mon_on = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   wire  [7:0]  databus_a;
   wire  [7:0]  databus_b;

   spart_driver_if bus_a ();
   spart_driver_if bus_b ();

   always #5 clk = ~clk;

   spart_driver #(.POLL_GAP(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .div      (div),
      .bus      (bus_a),
      .databus  (databus_a),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .cfg_done (cfg_done)
   );

   spart_driver #(.POLL_GAP(0)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .div      (div),
      .bus      (bus_b),
      .databus  (databus_b),
      .tx_data  (8'h00),
      .tx_valid (1'b0),
      .tx_ready (b_tx_ready),
      .rx_data  (b_rx_data),
      .rx_valid (b_rx_valid),
      .rx_ready (1'b0),
      .cfg_done (b_cfg_done)
   );

   // bus_interface model: drives databus only during read accesses.
   always_comb begin
      slave_en_a  = bus_a.iocs && bus_a.iorw;
      slave_val_a = (bus_a.ioaddr == 2'b01) ? {6'h0, tbr, rda} : rd_byte;
   end
   assign databus_a = slave_en_a ? slave_val_a : 8'hzz;
   assign databus_b = (bus_b.iocs && bus_b.iorw) ? 8'h00 : 8'hzz;

   // Bus sanity: idle cycles keep iorw=1 (driver off), reads see only the SPART's byte.
   always @(negedge clk) begin
      if (mon_on) begin
         if (!bus_a.iocs) begin
            checks++;
            assert (bus_a.iorw === 1'b1) else begin
               errors++;
               $error("[TB] FAIL idle_iorw observed=%b expected=1", bus_a.iorw);
            end
         end else if (bus_a.iorw) begin
            checks++;
            assert (databus_a === slave_val_a) else begin
               errors++;
               $error("[TB] FAIL read_bus observed=%h expected=%h", databus_a, slave_val_a);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_stimulus(input logic new_rda, input logic new_tbr, input logic [7:0] new_byte);
      rda     = new_rda;
      tbr     = new_tbr;
      rd_byte = new_byte;
   endtask

   task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic is_poll();
      return bus_a.iocs && bus_a.iorw && (bus_a.ioaddr == 2'b01);
   endfunction

   function automatic logic is_rd();
      return bus_a.iocs && bus_a.iorw && (bus_a.ioaddr == 2'b00);
   endfunction

   function automatic logic is_wr();
      return bus_a.iocs && !bus_a.iorw;
   endfunction

   initial begin
      int reads;
      int polls;
      int writes;
      int last_poll;
      int wr_gap;
      int rd_cyc;
      int wr_cyc;
      int poll_mid;
      logic found;
      logic [7:0] wr_data;
      logic [1:0] wr_addr;

      rst      = 1'b1;
      div      = 16'h028B;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      apply_stimulus(1'b0, 1'b0, 8'h00);
      repeat (3) tick();

      // Reset state
      check_output("rst_bus", {13'h0, bus_a.iocs, bus_a.iorw, bus_a.ioaddr}, {13'h0, 1'b0, 1'b1, 2'b00});
      check_output("rst_host", {tx_ready, rx_valid, cfg_done}, {1'b1, 1'b0, 1'b0});
      check_output("rst_rx_data", rx_data, 8'h00);

      // Config sequence
      rst    = 1'b0;
      mon_on = 1'b1;
      tick();
      check_output("cfg_lo", {bus_a.iocs, bus_a.iorw, bus_a.ioaddr, databus_a}, {1'b1, 1'b0, 2'b10, 8'h8B});
      tick();
      check_output("cfg_turn1", bus_a.iocs, 1'b0);
      tick();
      check_output("cfg_hi", {bus_a.iocs, bus_a.iorw, bus_a.ioaddr, databus_a}, {1'b1, 1'b0, 2'b11, 8'h02});
      tick();
      check_output("cfg_done_cyc3", {cfg_done, bus_a.iocs}, {1'b1, 1'b0});
      tick();
      check_output("first_poll", {cfg_done, bus_a.iocs, bus_a.iorw, bus_a.ioaddr}, {1'b1, 1'b1, 1'b1, 2'b01});
      check_output("b_first_poll", {b_cfg_done, bus_b.iocs, bus_b.ioaddr}, {1'b1, 1'b1, 2'b01});

      // Poll gap: period 4 with POLL_GAP=2, period 2 with POLL_GAP=0
      tick();
      check_output("gap_c5", {bus_a.iocs, bus_b.iocs}, 2'b00);
      tick();
      check_output("gap_c6", {bus_a.iocs, bus_b.iocs}, 2'b01);
      tick();
      check_output("gap_c7", {bus_a.iocs, bus_b.iocs}, 2'b00);
      tick();
      check_output("gap_c8_poll", {bus_a.iocs, bus_a.ioaddr, bus_b.iocs}, {1'b1, 2'b01, 1'b1});

      // RX: byte waiting during this POLL
      apply_stimulus(1'b1, 1'b0, 8'h5A);
      tick();
      check_output("rx_turn", bus_a.iocs, 1'b0);
      tick();
      check_output("rx_rd_data", {bus_a.iocs, bus_a.iorw, bus_a.ioaddr}, {1'b1, 1'b1, 2'b00});
      tick();
      check_output("rx_captured", {rx_valid, rx_data}, {1'b1, 8'h5A});

      // Backpressure: no more reads while rx_valid
      reads = 0;
      polls = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (is_rd()) reads++;
         if (is_poll()) polls++;
      end
      check_output("rx_backpressure_reads", 16'(reads), 16'd0);
      check_output("rx_polling_continues", 16'(polls > 0), 16'd1);
      check_output("rx_valid_held", {rx_valid, rx_data}, {1'b1, 8'h5A});

      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check_output("rx_cleared", rx_valid, 1'b0);
      apply_stimulus(1'b1, 1'b0, 8'hA6);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         if (is_rd()) found = 1'b1;
      end
      check_output("rx_second_read", found, 1'b1);
      tick();
      check_output("rx_second_byte", {rx_valid, rx_data}, {1'b1, 8'hA6});
      apply_stimulus(1'b0, 1'b0, 8'h00);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check_output("rx_drained", rx_valid, 1'b0);

      // TX: byte held while tbr=0
      tx_data  = 8'hC3;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check_output("tx_accepted", tx_ready, 1'b0);
      polls  = 0;
      writes = 0;
      for (int i = 0; i < 60 && polls < 5; i++) begin
         tick();
         if (is_poll()) polls++;
         if (is_wr()) writes++;
      end
      check_output("tx_polls_seen", 16'(polls), 16'd5);
      check_output("tx_no_write_tbr0", 16'(writes), 16'd0);
      tick();
      apply_stimulus(1'b0, 1'b1, 8'h00);
      writes    = 0;
      last_poll = -100;
      wr_gap    = -1;
      wr_addr   = 2'b11;
      wr_data   = 8'h00;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (is_poll()) last_poll = cyc;
         if (is_wr()) begin
            writes++;
            wr_addr = bus_a.ioaddr;
            wr_data = databus_a;
            wr_gap  = cyc - last_poll;
         end
      end
      check_output("tx_one_write", 16'(writes), 16'd1);
      check_output("tx_write_word", {wr_addr, wr_data}, {2'b00, 8'hC3});
      check_output("tx_write_after_poll", 16'(wr_gap), 16'd2);
      check_output("tx_ready_back", tx_ready, 1'b1);

      // Simultaneous rda and tbr with a byte pending: read first
      apply_stimulus(1'b1, 1'b1, 8'h3C);
      tx_data  = 8'h77;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      rd_cyc   = -1000;
      wr_cyc   = -1000;
      poll_mid = -1000;
      wr_data  = 8'h00;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (is_rd() && rd_cyc < 0) rd_cyc = cyc;
         if (is_poll() && rd_cyc >= 0 && wr_cyc < 0) poll_mid = cyc;
         if (is_wr() && wr_cyc < 0) begin
            wr_cyc  = cyc;
            wr_data = databus_a;
         end
      end
      check_output("simul_rd_seen", 16'(rd_cyc >= 0), 16'd1);
      check_output("simul_wr_after_rd", 16'(wr_cyc - rd_cyc), 16'd4);
      check_output("simul_poll_between", 16'(poll_mid - rd_cyc), 16'd2);
      check_output("simul_wr_data", wr_data, 8'h77);
      check_output("simul_rx_byte", {rx_valid, rx_data}, {1'b1, 8'h3C});

      // Reset in the middle of a WR_DATA cycle
      apply_stimulus(1'b0, 1'b1, 8'h00);
      tx_data  = 8'h11;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 24 && !found; i++) begin
         tick();
         if (is_wr()) found = 1'b1;
      end
      check_output("reset_wr_found", found, 1'b1);
      rst = 1'b1;
      tick();
      check_output("reset_mid_bus", {bus_a.iocs, bus_a.iorw}, {1'b0, 1'b1});
      check_output("reset_mid_host", {tx_ready, cfg_done, rx_valid}, {1'b1, 1'b0, 1'b0});
      check_output("reset_mid_rx_data", rx_data, 8'h00);
      div = 16'h1234;
      tick();
      rst = 1'b0;
      tick();
      check_output("restart_cfg_lo", {bus_a.iocs, bus_a.iorw, bus_a.ioaddr, databus_a}, {1'b1, 1'b0, 2'b10, 8'h34});
      tick();
      tick();
      check_output("restart_cfg_hi", {bus_a.iocs, bus_a.iorw, bus_a.ioaddr, databus_a}, {1'b1, 1'b0, 2'b11, 8'h12});
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
